// File: rtl/apb_pkg.sv
// Shared FSM state type and default sizing for the APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;
    localparam int APB_TMR_W   = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY; flags the cycle the count reaches TIMEOUT.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [APB_TMR_W-1:0] LP_LAST = APB_TMR_W'(TIMEOUT - 1);

    logic [APB_TMR_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted on the waiting cycle whose increment brings the count to TIMEOUT.
    assign o_expired = i_enable && (r_count == LP_LAST);

endmodule

// File: rtl/apb_master.sv
// APB master bridge: accepts one command at a time, runs SETUP/ACCESS with wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    apb_state_t        r_state;
    apb_state_t        w_state_nxt;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_in_access;
    logic              w_done;
    logic              w_abort;
    logic              w_expired;
    logic              w_accept;

    assign w_in_access = (r_state == ACCESS);
    assign w_done      = w_in_access && PREADY;
    // PREADY wins over an expiring timer in the same cycle.
    assign w_abort     = w_in_access && !PREADY && w_expired;
    assign cmd_ready   = !PRESET && ((r_state == IDLE) || w_done);
    assign w_accept    = cmd_valid && cmd_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_clear   (w_accept),
        .i_enable  (w_in_access && !PREADY),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = SETUP;
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (w_done) begin
                    w_state_nxt = w_accept ? SETUP : IDLE;
                end else if (w_abort) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus request fields are captured only on accept so they hold through ACCESS and IDLE.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_done || w_abort;
            r_rsp_err   <= w_abort;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
            end
        end
    end

    assign PSEL      = (r_state != IDLE);
    assign PENABLE   = w_in_access;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: per-cycle expectations come from a transfer-timeline model.
module tb_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int N   = 78;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    initial forever #5 PCLK = ~PCLK;

    // Stimulus per cycle
    logic        s_rst   [N];
    logic        s_valid [N];
    logic        s_write [N];
    logic        s_pready[N];
    logic [31:0] s_addr  [N];
    logic [31:0] s_wdata [N];
    logic [31:0] s_prdata[N];
    // Expected outputs per cycle
    logic        e_psel  [N];
    logic        e_pen   [N];
    logic        e_pwrite[N];
    logic        e_ready [N];
    logic        e_rv    [N];
    logic        e_err   [N];
    logic [31:0] e_paddr [N];
    logic [31:0] e_pwdata[N];
    logic [31:0] e_rdata [N];

    int   cur_cyc = 0;
    logic running = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pen_t2 = 0;
    int   psel_b2b = 0;
    int          rsp_cyc[$];
    logic [31:0] rsp_dat[$];
    logic        rsp_er [$];

    // A transfer accepted in cycle s holds SETUP at s+1, then L ACCESS cycles,
    // where L = waits+1 if the slave answers within TIMEOUT, else TIMEOUT (abort).
    task automatic plan_xfer(input int s, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int waits);
        int  len;
        int  e;
        bit  ok;
        ok  = (waits < TMO);
        len = ok ? waits + 1 : TMO;
        e   = s + 1 + len;
        s_valid[s] = 1'b1;
        s_write[s] = wr;
        s_addr[s]  = addr;
        s_wdata[s] = wd;
        for (int c = s + 1; c <= e && c < N; c++) begin
            e_psel[c]  = 1'b1;
            e_ready[c] = 1'b0;
            if (c >= s + 2) e_pen[c] = 1'b1;
        end
        if (ok && e < N) begin
            s_pready[e] = 1'b1;
            s_prdata[e] = rd;
            e_ready[e]  = 1'b1;
        end
        for (int c = s + 1; c < N; c++) begin
            e_pwrite[c] = wr;
            e_paddr[c]  = addr;
            e_pwdata[c] = wd;
        end
        if (e + 1 < N) begin
            e_rv[e + 1]  = 1'b1;
            e_err[e + 1] = !ok;
        end
        for (int c = e + 1; c < N; c++) e_rdata[c] = (ok && !wr) ? rd : 32'h0;
    endtask

    // Reset over cycles [c0, c1): everything zero, any in-flight transfer vanishes.
    task automatic plan_reset(input int c0, input int c1);
        for (int c = c0; c < c1 && c < N; c++) begin
            s_rst[c]   = 1'b1;
            e_ready[c] = 1'b0;
        end
        for (int c = c0; c < c0 + 16 && c < N; c++) begin
            e_psel[c]   = 1'b0;
            e_pen[c]    = 1'b0;
            e_rv[c]     = 1'b0;
            e_err[c]    = 1'b0;
            s_pready[c] = 1'b0;
            if (c >= c1) e_ready[c] = 1'b1;
        end
        for (int c = c0; c < N; c++) begin
            e_pwrite[c] = 1'b0;
            e_paddr[c]  = 32'h0;
            e_pwdata[c] = 32'h0;
            e_rdata[c]  = 32'h0;
        end
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            s_rst[c]    = 1'b0;
            s_valid[c]  = 1'b0;
            s_write[c]  = ((c % 2) == 1);
            s_pready[c] = 1'b0;
            s_addr[c]   = 32'hFFFF_0000 | 32'(c);
            s_wdata[c]  = 32'hEEEE_0000 | 32'(c);
            s_prdata[c] = 32'hBAD0_0000 | 32'(c);
            e_psel[c]   = 1'b0;
            e_pen[c]    = 1'b0;
            e_pwrite[c] = 1'b0;
            e_ready[c]  = 1'b1;
            e_rv[c]     = 1'b0;
            e_err[c]    = 1'b0;
            e_paddr[c]  = 32'h0;
            e_pwdata[c] = 32'h0;
            e_rdata[c]  = 32'h0;
        end
        plan_reset(0, 3);
        plan_xfer(4,  1'b1, 32'h10, 32'hA5A5_0001, 32'h5555_5555, 0);
        plan_xfer(9,  1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 3);
        plan_xfer(18, 1'b1, 32'h30, 32'h1111_2222, 32'h0,         0);
        plan_xfer(20, 1'b1, 32'h34, 32'h3333_4444, 32'h0,         0);
        plan_xfer(26, 1'b0, 32'h40, 32'h0,         32'h0,         99);
        plan_xfer(35, 1'b0, 32'h44, 32'h0,         32'h1234_5678, 3);
        plan_xfer(44, 1'b1, 32'h48, 32'h0000_CAFE, 32'h7777_7777, 1);
        plan_xfer(50, 1'b0, 32'h50, 32'h0,         32'h0BAD_F00D, 0);
        plan_xfer(57, 1'b0, 32'h60, 32'h0,         32'h6666_6666, 99);
        plan_reset(60, 63);
        plan_xfer(66, 1'b1, 32'h70, 32'h0000_7777, 32'h0,         0);
        // Command presented while busy must be ignored; cmd_valid held high across the b2b pair.
        s_valid[12] = 1'b1;
        s_write[12] = 1'b1;
        s_addr[12]  = 32'h99;
        s_valid[19] = 1'b1;
        s_write[19] = 1'b1;
        s_addr[19]  = 32'h34;
        s_wdata[19] = 32'h3333_4444;
        s_pready[8]  = 1'b1;
        s_pready[25] = 1'b1;

        for (int c = 0; c < N; c++) begin
            @(posedge PCLK);
            #1;
            PRESET    = s_rst[c];
            cmd_valid = s_valid[c];
            cmd_write = s_write[c];
            cmd_addr  = s_addr[c];
            cmd_wdata = s_wdata[c];
            PREADY    = s_pready[c];
            PRDATA    = s_prdata[c];
            cur_cyc   = c;
            running   = 1'b1;
        end
    end

    initial begin
        #(N * 40);
        $display("FAIL watchdog: bench did not complete by cycle %0d", N * 4);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cur_cyc, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (running) begin
            chk("psel",      32'(PSEL),      32'(e_psel[cur_cyc]));
            chk("penable",   32'(PENABLE),   32'(e_pen[cur_cyc]));
            chk("pwrite",    32'(PWRITE),    32'(e_pwrite[cur_cyc]));
            chk("paddr",     PADDR,          e_paddr[cur_cyc]);
            chk("pwdata",    PWDATA,         e_pwdata[cur_cyc]);
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready[cur_cyc]));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[cur_cyc]));
            chk("rsp_err",   32'(rsp_err),   32'(e_err[cur_cyc]));
            chk("rsp_rdata", rsp_rdata,      e_rdata[cur_cyc]);
            if (PENABLE && cur_cyc >= 9 && cur_cyc <= 16) pen_t2++;
            if (PSEL && cur_cyc >= 18 && cur_cyc <= 23) psel_b2b++;
            if (rsp_valid) begin
                rsp_cyc.push_back(cur_cyc);
                rsp_dat.push_back(rsp_rdata);
                rsp_er.push_back(rsp_err);
            end
            if (cur_cyc == N - 1) begin
                chk("n_responses", 32'(rsp_cyc.size()), 32'd9);
                if (rsp_cyc.size() == 9) begin
                    chk("wr0_rsp_cycle",    32'(rsp_cyc[0]), 32'd7);
                    chk("rd3_rsp_cycle",    32'(rsp_cyc[1]), 32'd15);
                    chk("rd3_rdata",        rsp_dat[1],      32'hDEAD_BEEF);
                    chk("b2b_rsp_gap",      32'(rsp_cyc[3] - rsp_cyc[2]), 32'd2);
                    chk("tmo_rsp_cycle",    32'(rsp_cyc[4]), 32'd32);
                    chk("tmo_err",          32'(rsp_er[4]),  32'd1);
                    chk("tmo_rdata",        rsp_dat[4],      32'h0);
                    chk("ready4_err",       32'(rsp_er[5]),  32'd0);
                    chk("ready4_rdata",     rsp_dat[5],      32'h1234_5678);
                    chk("wr_clears_rdata",  rsp_dat[6],      32'h0);
                    chk("post_rst_rsp_cyc", 32'(rsp_cyc[8]), 32'd69);
                end
                chk("rd3_penable_cycles", 32'(pen_t2),   32'd4);
                chk("b2b_psel_cycles",    32'(psel_b2b), 32'd4);
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

endmodule
